boolean_propose_multi_flip: RTL
===============================

# boolean_propose_multi_flip

Next-generation Boolean proposal unit for the MCMC constraint solver. It takes the current Boolean assignment and produces a proposed assignment in one of two modes: flipping one caller-chosen variable, or flipping up to `MAX_FLIPS` distinct, non-frozen variables chosen by an internal LFSR. A valid/ack handshake connects it to the acceptance stage downstream. It sits between the sampler control FSM and the energy/acceptance evaluation.

## Interface
- `MAX_BIT_WIDTH_OF_VARIABLES_INDEX`, 4: index width; N = 2**MAX_BIT_WIDTH_OF_VARIABLES_INDEX variables.
- `MAX_FLIPS`, 4: maximum flips per proposal (1..N).
- `FLIP_COUNT_WIDTH`, 3: width of `in_num_flips`; must hold `MAX_FLIPS`.

Ports:
- `in_clock`  in  1  sole clock, rising edge.
- `in_reset_n`  in  1  reset, asynchronous, active-low.
- `in_start`  in  1  proposal request; sampled only in IDLE.
- `in_mode`  in  1  0 = random multi-flip, 1 = explicit single flip.
- `in_num_flips`  in  FLIP_COUNT_WIDTH  random-mode flip count; 0 is treated as 1, values above `MAX_FLIPS` are clamped to `MAX_FLIPS`.
- `in_variable_to_be_changed_index`  in  MAX_BIT_WIDTH_OF_VARIABLES_INDEX  explicit-mode index.
- `in_current_assignment_boolean`  in  N  assignment, captured at start.
- `in_frozen_mask`  in  N  1 = variable must not flip; captured at start.
- `in_seed`  in  16  LFSR seed.
- `in_seed_load`  in  1  load seed (IDLE only).
- `in_ack`  in  1  consumer accepts the result.
- `out_new_assignment_Boolean`  out  N  proposed assignment.
- `out_flipped_mask`  out  N  bits flipped in this proposal.
- `out_short`  out  1  fewer flips than requested.
- `out_valid`  out  1  result valid.
- `out_busy`  out  1  high in FLIP and DONE.

## Operation
- States:
  - IDLE → FLIP on `in_start`.
  - FLIP → DONE once the target is reached or attempts are exhausted.
  - DONE → IDLE on `in_ack`.
- On start, capture:
  - assignment and frozen mask;
  - target = 1 in explicit mode, otherwise the clamped `in_num_flips`;
  - flip count and attempt count cleared; flipped mask cleared.
- FLIP, one candidate per cycle:
  - Candidate index: explicit index in mode 1, otherwise `lfsr[MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]`.
  - Rejected if frozen or already set in the flipped mask. Otherwise set its mask bit and increment the flip count.
  - The attempt count increments on every candidate.
  - Attempt limit is 4*`MAX_FLIPS` in random mode and 1 in explicit mode.
- LFSR behaviour:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Advances once per FLIP cycle only.
  - Reset value 16'hACE1.
  - `in_seed_load` in IDLE loads `in_seed`; a seed of 0 loads 16'hACE1 instead.
  - `in_seed_load` outside IDLE is ignored.
- Result outputs:
  - `out_new_assignment_Boolean` = captured assignment XOR flipped mask.
  - `out_short` = flip count < target.
  - Both stable throughout DONE.
- `in_start` outside IDLE is ignored. `in_ack` outside DONE is ignored.

## Timing
- Reset values:
  - state IDLE, LFSR 16'hACE1;
  - `out_valid`, `out_busy`, `out_short` all 0;
  - `out_flipped_mask` and `out_new_assignment_Boolean` both 0.
- Explicit mode: start at cycle 0, FLIP at cycle 1, `out_valid` high at cycle 2.
- Random mode: `out_valid` is high 1 + (candidates used) cycles after start; at most 1 + 4*`MAX_FLIPS`.
- `out_valid` holds until an `in_ack` edge. The next cycle is IDLE with `out_valid` = 0 and outputs held.
- A new start in IDLE follows the IDLE cycle, so the minimum proposal period is latency + 1 cycle.
- Reset asserted mid-FLIP or mid-DONE returns immediately to reset values. No partial result is emitted.

## Structure
- Shared package `mcmc_boolean_pkg`:
  - state enum IDLE/FLIP/DONE;
  - LFSR reset constant 16'hACE1;
  - LFSR tap constant;
  - attempt multiplier 4.
- Sub-module `lfsr16`: with `in_clock`, `in_reset_n`, advance, load, seed, and value.
- The FSM, counters and mask logic stay in the top module.

## Test plan
All cases use the default parameters (N = 16).

- **Explicit flip:** mode 1, index 3, assignment 16'h0000, mask 0, start.
  - Expect `out_valid` at cycle 2, new assignment 16'h0008, flipped mask 16'h0008, short 0.
- **Explicit frozen:** mode 1, index 5, frozen 16'h0020, assignment 16'hFFFF.
  - Expect new assignment 16'hFFFF, mask 0, short 1, valid at cycle 2.
- **Random three flips:** seed 16'h1234 loaded, `in_num_flips` = 3, frozen 0.
  - Expect popcount(mask) = 3, new = assignment XOR mask, short 0.
  - Valid must match the reference LFSR model cycle count.
- **All frozen:** frozen 16'hFFFF, `in_num_flips` = 2, random mode.
  - Expect valid after exactly 17 cycles, mask 0, short 1.
- **Handshake and clamping:** `in_ack` held low for 10 cycles, then high.
  - Outputs stable while waiting; IDLE follows; `in_start` during DONE is ignored.
  - `in_num_flips` = 7 is clamped to 4; `in_num_flips` = 0 yields one flip.
- **Reset mid-FLIP:** assert `in_reset_n` = 0 during the FLIP of a random 4-flip proposal.
  - All outputs 0 and LFSR 16'hACE1 immediately; no valid appears after release.

Source files
------------

// File: rtl/mcmc_boolean_pkg.sv
// rtl/mcmc_boolean_pkg.sv - shared types and constants for the Boolean proposal unit
package mcmc_boolean_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLIP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // LFSR state after reset and the substitute for an all-zero seed
    localparam logic [15:0] LFSR_RESET = 16'hACE1;

    // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Random-mode attempt budget is this many candidates per requested flip
    localparam int ATTEMPT_MULT = 4;

    // One Fibonacci step: shift left, feedback is the parity of the tapped bits
    function automatic logic [15:0] lfsr_next(input logic [15:0] value);
        return {value[14:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR with seed load and gated advance
import mcmc_boolean_pkg::*;

module lfsr16 (
    input  logic        in_clock,
    input  logic        in_reset_n,
    input  logic        in_advance,
    input  logic        in_load,
    input  logic [15:0] in_seed,
    output logic [15:0] out_value
);

    logic [15:0] value;

    // Load has priority; a zero seed would lock the register, so it maps to the reset value
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            value <= LFSR_RESET;
        end else if (in_load) begin
            value <= (in_seed == 16'h0000) ? LFSR_RESET : in_seed;
        end else if (in_advance) begin
            value <= lfsr_next(value);
        end
    end

    assign out_value = value;

endmodule

// File: rtl/boolean_propose_multi_flip.sv
// rtl/boolean_propose_multi_flip.sv - Boolean proposal unit: explicit single flip or random multi-flip
import mcmc_boolean_pkg::*;

module boolean_propose_multi_flip #(
    parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX = 4,
    parameter int MAX_FLIPS                        = 4,
    parameter int FLIP_COUNT_WIDTH                 = 3
) (
    input  logic                                        in_clock,
    input  logic                                        in_reset_n,
    input  logic                                        in_start,
    input  logic                                        in_mode,
    input  logic [FLIP_COUNT_WIDTH-1:0]                 in_num_flips,
    input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] in_variable_to_be_changed_index,
    input  logic [(2**MAX_BIT_WIDTH_OF_VARIABLES_INDEX)-1:0] in_current_assignment_boolean,
    input  logic [(2**MAX_BIT_WIDTH_OF_VARIABLES_INDEX)-1:0] in_frozen_mask,
    input  logic [15:0]                                 in_seed,
    input  logic                                        in_seed_load,
    input  logic                                        in_ack,
    output logic [(2**MAX_BIT_WIDTH_OF_VARIABLES_INDEX)-1:0] out_new_assignment_Boolean,
    output logic [(2**MAX_BIT_WIDTH_OF_VARIABLES_INDEX)-1:0] out_flipped_mask,
    output logic                                        out_short,
    output logic                                        out_valid,
    output logic                                        out_busy
);

    localparam int IW            = MAX_BIT_WIDTH_OF_VARIABLES_INDEX;
    localparam int N             = 2 ** IW;
    localparam int FCW           = FLIP_COUNT_WIDTH;
    localparam int ATTEMPT_LIMIT = ATTEMPT_MULT * MAX_FLIPS;
    localparam int AW            = $clog2(ATTEMPT_LIMIT + 1);

    localparam logic [FCW-1:0] MAX_FLIPS_C     = FCW'(MAX_FLIPS);
    localparam logic [FCW-1:0] ONE_FLIP_C      = FCW'(1);
    localparam logic [AW-1:0]  ATTEMPT_LIMIT_C = AW'(ATTEMPT_LIMIT);
    localparam logic [AW-1:0]  ONE_ATTEMPT_C   = AW'(1);

    state_t          state;
    logic            mode_q;
    logic [IW-1:0]   index_q;
    logic [N-1:0]    assignment_q;
    logic [N-1:0]    frozen_q;
    logic [N-1:0]    mask_q;
    logic [FCW-1:0]  target_q;
    logic [FCW-1:0]  count_q;
    logic [AW-1:0]   attempts_q;
    logic            valid_q;
    logic            busy_q;

    logic [15:0]     lfsr_value;
    logic            unused_lfsr_bits;
    logic [FCW-1:0]  start_target;
    logic [IW-1:0]   candidate;
    logic            accept;
    logic [FCW-1:0]  count_next;
    logic [AW-1:0]   attempts_next;
    logic [AW-1:0]   attempt_limit;
    logic            finish;

    // Only the low index bits pick a candidate
    assign unused_lfsr_bits = ^lfsr_value[15:IW];

    lfsr16 u_lfsr (
        .in_clock   (in_clock),
        .in_reset_n (in_reset_n),
        .in_advance (state == ST_FLIP),
        .in_load    (in_seed_load && (state == ST_IDLE)),
        .in_seed    (in_seed),
        .out_value  (lfsr_value)
    );

    // Flip target latched at start: explicit mode is always one, random mode is clamped to 1..MAX_FLIPS
    always_comb begin
        start_target = in_num_flips;
        if (in_mode) begin
            start_target = ONE_FLIP_C;
        end else if (in_num_flips == '0) begin
            start_target = ONE_FLIP_C;
        end else if (in_num_flips > MAX_FLIPS_C) begin
            start_target = MAX_FLIPS_C;
        end
    end

    // Candidate evaluation for the current FLIP cycle and the exit condition it produces
    always_comb begin
        candidate     = mode_q ? index_q : lfsr_value[IW-1:0];
        accept        = !frozen_q[candidate] && !mask_q[candidate];
        count_next    = count_q + {{(FCW-1){1'b0}}, accept};
        attempts_next = attempts_q + ONE_ATTEMPT_C;
        attempt_limit = mode_q ? ONE_ATTEMPT_C : ATTEMPT_LIMIT_C;
        finish        = (count_next >= target_q) || (attempts_next >= attempt_limit);
    end

    // Proposal FSM: capture on start, one candidate per FLIP cycle, hold result until ack
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state        <= ST_IDLE;
            mode_q       <= 1'b0;
            index_q      <= '0;
            assignment_q <= '0;
            frozen_q     <= '0;
            mask_q       <= '0;
            target_q     <= '0;
            count_q      <= '0;
            attempts_q   <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (in_start) begin
                        mode_q       <= in_mode;
                        index_q      <= in_variable_to_be_changed_index;
                        assignment_q <= in_current_assignment_boolean;
                        frozen_q     <= in_frozen_mask;
                        mask_q       <= '0;
                        target_q     <= start_target;
                        count_q      <= '0;
                        attempts_q   <= '0;
                        busy_q       <= 1'b1;
                        state        <= ST_FLIP;
                    end
                end
                ST_FLIP: begin
                    attempts_q <= attempts_next;
                    count_q    <= count_next;
                    if (accept) begin
                        mask_q <= mask_q | (N'(1) << candidate);
                    end
                    if (finish) begin
                        valid_q <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (in_ack) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_new_assignment_Boolean = assignment_q ^ mask_q;
    assign out_flipped_mask           = mask_q;
    assign out_short                  = (count_q < target_q);
    assign out_valid                  = valid_q;
    assign out_busy                   = busy_q;

endmodule
